mc_unit_scheduler: RTL

MC_UNIT_SCHEDULER -- requirements
Module: mc_unit_scheduler

---
 rtl/mc_unit_scheduler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mc_unit_scheduler.sv
// Multi-cycle unit scheduler: issues one MUL/DIV/FPU operation at a time from EX,
// stalls the front of the pipe until the result retires, and discards flushed results.
module mc_unit_scheduler #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [1:0]       req_unit,
  input  logic [5:0]       req_rd,
  input  logic             clear,
  input  logic             mul_busy,
  input  logic             mul_ready,
  input  logic             div_busy,
  input  logic             div_ready,
  input  logic             fpu_busy,
  input  logic             fpu_ready,
  input  logic [31:0]      mul_out,
  input  logic [31:0]      div_out,
  input  logic [31:0]      fpu_out,
  output logic             mul_load,
  output logic             div_load,
  output logic             fpu_load,
  output logic             stall,
  output logic             res_valid,
  output logic [31:0]      res_data,
  output logic [5:0]       res_rd,
  output logic [CNT_W-1:0] busy_cycles
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [1:0]  unit_q;
  logic [5:0]  rd_q;
  logic        issue, start;
  logic        sel_busy, sel_ready;
  logic        lat_ready;
  logic [31:0] lat_out;

  assign issue = (state == IDLE) && req_valid && (req_unit != 2'd0) && !clear;

  // Status of the requested unit (IDLE decisions) and of the latched unit (WAIT/DRAIN).
  always_comb begin
    sel_busy  = 1'b0;
    sel_ready = 1'b0;
    case (req_unit)
      2'd1:    begin sel_busy = mul_busy; sel_ready = mul_ready; end
      2'd2:    begin sel_busy = div_busy; sel_ready = div_ready; end
      2'd3:    begin sel_busy = fpu_busy; sel_ready = fpu_ready; end
      default: ;
    endcase
    lat_ready = 1'b0;
    lat_out   = '0;
    case (unit_q)
      2'd1:    begin lat_ready = mul_ready; lat_out = mul_out; end
      2'd2:    begin lat_ready = div_ready; lat_out = div_out; end
      2'd3:    begin lat_ready = fpu_ready; lat_out = fpu_out; end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    stall     = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          stall = 1'b1;
          if (!sel_busy && !sel_ready) begin
            start     = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (clear)          state_nxt = lat_ready ? IDLE : DRAIN;
        else if (lat_ready) state_nxt = DONE;
      end
      DONE: begin
        res_valid = !clear;
        state_nxt = IDLE;
      end
      DRAIN: begin
        stall = req_valid && (req_unit != 2'd0) && !clear;
        if (lat_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs are combinational, so gate them so reset forces them low immediately.
    if (reset) begin
      start     = 1'b0;
      stall     = 1'b0;
      res_valid = 1'b0;
    end
  end

  assign mul_load = start && (req_unit == 2'd1);
  assign div_load = start && (req_unit == 2'd2);
  assign fpu_load = start && (req_unit == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      unit_q      <= '0;
      rd_q        <= '0;
      res_data    <= '0;
      res_rd      <= '0;
      busy_cycles <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        unit_q <= req_unit;
        rd_q   <= req_rd;
      end
      if (state == WAIT && lat_ready && !clear) begin
        res_data <= lat_out;
        res_rd   <= rd_q;
      end
      if ((state == WAIT || state == DRAIN) && busy_cycles != '1)
        busy_cycles <= busy_cycles + CNT_W'(1);
    end
  end

endmodule
